// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load handshake.
// A captured word is shifted out one bit per clock, MSB or LSB first; a new word
// can be accepted on the final bit cycle so frames run back-to-back with no gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the data bits, carried in state PARITY.
//
// state  | meaning
// IDLE   | no frame in progress, q/q_valid/done held low, ready for a word
// SHIFT  | data bits on q, cnt counts data bits still to follow the current one
// PARITY | parity bit on q (PISO_PARITY_EN builds only)

module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             q_nxt, q_valid_nxt, done_nxt;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par, par_nxt;
`endif

  // Ready while idle or while the last bit of the frame is on q.
  always_comb begin
    load_ready = 1'b0;
    if (state == IDLE) begin
      load_ready = 1'b1;
    end
`ifdef PISO_PARITY_EN
    else if (state == PARITY) begin
      load_ready = 1'b1;
    end
`else
    else if (state == SHIFT && cnt == '0) begin
      load_ready = 1'b1;
    end
`endif
  end

  assign accept = load_valid & load_ready;

  // Next-state and next-output decode; a new word overrides whatever the frame would do.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    q_nxt       = 1'b0;
    q_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
`ifdef PISO_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      SHIFT: begin
        if (cnt != '0) begin
          q_nxt       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
          shreg_nxt   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          cnt_nxt     = cnt - 1'b1;
          q_valid_nxt = 1'b1;
`ifndef PISO_PARITY_EN
          done_nxt    = (cnt == CW'(1));
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_nxt   = PARITY;
          q_nxt       = par;
          q_valid_nxt = 1'b1;
          done_nxt    = 1'b1;
`else
          state_nxt   = IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (accept) begin
      state_nxt   = SHIFT;
      q_nxt       = MSB_FIRST ? din[WIDTH-1] : din[0];
      shreg_nxt   = MSB_FIRST ? (din << 1) : (din >> 1);
      cnt_nxt     = CW'(WIDTH - 1);
      q_valid_nxt = 1'b1;
      done_nxt    = 1'b0;
`ifdef PISO_PARITY_EN
      par_nxt     = ^din;
`endif
    end
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
`ifdef PISO_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

endmodule
